// File: rtl/key_scan_module_pkg.sv
// Shared definitions for the key scan front end: debounce FSM states and default timing.
package key_scan_module_pkg;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_PWAIT   = 2'd1,
    KS_PRESSED = 2'd2,
    KS_RWAIT   = 2'd3
  } key_fsm_e;

  localparam logic [15:0] T1MS_DEF   = 16'd50_000;
  localparam logic [4:0]  DEB_MS_DEF = 5'd20;

endpackage

// File: rtl/key_scan_module_debounce.sv
// One-key debounce cell: accepts a level change only after DEB_MS consecutive stable ticks.
module key_debounce_cell
  import key_scan_module_pkg::*;
#(
  parameter logic [4:0] DEB_MS = DEB_MS_DEF
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic s,
  input  logic tick,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse
);

  key_fsm_e   state, next_state;
  logic [4:0] cnt, next_cnt;
  logic       press_d, release_d;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= KS_IDLE;
      cnt           <= 5'd0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= next_state;
      cnt           <= next_cnt;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  // Aborts back to the stable state are checked every cycle; counting only happens on tick.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    press_d    = 1'b0;
    release_d  = 1'b0;
    unique case (state)
      KS_IDLE: begin
        if (s) begin
          next_state = KS_PWAIT;
          next_cnt   = 5'd0;
        end
      end
      KS_PWAIT: begin
        if (!s) begin
          next_state = KS_IDLE;
          next_cnt   = 5'd0;
        end else if (tick) begin
          if (cnt == DEB_MS - 5'd1) begin
            next_state = KS_PRESSED;
            next_cnt   = 5'd0;
            press_d    = 1'b1;
          end else begin
            next_cnt = cnt + 5'd1;
          end
        end
      end
      KS_PRESSED: begin
        if (!s) begin
          next_state = KS_RWAIT;
          next_cnt   = 5'd0;
        end
      end
      KS_RWAIT: begin
        if (s) begin
          next_state = KS_PRESSED;
          next_cnt   = 5'd0;
        end else if (tick) begin
          if (cnt == DEB_MS - 5'd1) begin
            next_state = KS_IDLE;
            next_cnt   = 5'd0;
            release_d  = 1'b1;
          end else begin
            next_cnt = cnt + 5'd1;
          end
        end
      end
      default: begin
        next_state = KS_IDLE;
        next_cnt   = 5'd0;
      end
    endcase
  end

  assign key_state = (state == KS_PRESSED) || (state == KS_RWAIT);

endmodule

// File: rtl/key_scan_module.sv
// Debounced 8-key front end: synchronisers, shared 1 ms tick, per-key debounce cells and event encoder.
module key_scan_module
  import key_scan_module_pkg::*;
#(
  parameter logic [15:0] T1MS   = T1MS_DEF,
  parameter logic [4:0]  DEB_MS = DEB_MS_DEF,
  parameter int          NKEY   = 8
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [NKEY-1:0] Key_In,
  output logic [NKEY-1:0] Key_State,
  output logic [NKEY-1:0] Key_Press,
  output logic [NKEY-1:0] Key_Release,
  output logic            Key_Valid,
  output logic [2:0]      Key_Code,
  output logic            Key_Multi
);

  logic [NKEY-1:0] sync1, sync2;
  logic [NKEY-1:0] s;
  logic [15:0]     count;
  logic            tick;
  logic [2:0]      low_idx;
  logic            multi;

  // Sync flops idle at 1 so a held key after reset is seen as a fresh press.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= Key_In;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count <= 16'd0;
    end else if (tick) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign tick = (count == T1MS - 16'd1);

  for (genvar i = 0; i < NKEY; i++) begin : g_cell
    key_debounce_cell #(
      .DEB_MS(DEB_MS)
    ) u_cell (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .s            (s[i]),
      .tick         (tick),
      .key_state    (Key_State[i]),
      .press_pulse  (Key_Press[i]),
      .release_pulse(Key_Release[i])
    );
  end

  // Downward scan leaves the lowest set index as the winner.
  always_comb begin
    low_idx = 3'd0;
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (Key_Press[i]) low_idx = 3'(i);
    end
  end

  assign multi = (Key_Press & (Key_Press - 1'b1)) != '0;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Key_Valid <= 1'b0;
      Key_Code  <= 3'd0;
      Key_Multi <= 1'b0;
    end else begin
      Key_Valid <= |Key_Press;
      Key_Multi <= multi;
      if (|Key_Press) Key_Code <= low_idx;
    end
  end

endmodule

// File: tb/tb_key_scan_module.sv
// Self-checking bench for key_scan_module: directed scenarios plus randomized multi-key presses.
module tb_key_scan_module;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b1;
  logic [7:0] Key_In = 8'hFF;
  logic [7:0] Key_State, Key_Press, Key_Release;
  logic       Key_Valid, Key_Multi;
  logic [2:0] Key_Code;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_drive = 0;
  int press_cnt[8];
  int rel_cnt[8];
  int press_cyc[8];
  int rel_cyc[8];
  logic [7:0] first_vec = 8'h00;
  logic [7:0] prev_press = 8'h00;
  logic [2:0] exp_code = 3'd0;

  key_scan_module #(
    .T1MS  (16'd10),
    .DEB_MS(5'd3),
    .NKEY  (8)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Key_In     (Key_In),
    .Key_State  (Key_State),
    .Key_Press  (Key_Press),
    .Key_Release(Key_Release),
    .Key_Valid  (Key_Valid),
    .Key_Code   (Key_Code),
    .Key_Multi  (Key_Multi)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] lowestIdx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic inWindow(input int lat);
    return (lat >= 23) && (lat <= 33);
  endfunction

  task automatic clearCounts();
    for (int k = 0; k < 8; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
      press_cyc[k] = -1;
      rel_cyc[k]   = -1;
    end
    first_vec = 8'h00;
  endtask

  task automatic applyStimulus(input logic [7:0] keys);
    @(negedge CLK);
    #1;
    Key_In  = keys;
    t_drive = cyc;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
    #2;
  endtask

  // Encoder reference: outputs one cycle after each press vector, code held otherwise.
  always @(negedge CLK) begin
    cyc++;
    if (!RSTn) begin
      prev_press = 8'h00;
      exp_code   = 3'd0;
    end else begin
      if (prev_press != 8'h00) begin
        exp_code = lowestIdx(prev_press);
        checkOutput("enc_valid", 32'(Key_Valid), 32'd1);
        checkOutput("enc_code", 32'(Key_Code), 32'(exp_code));
        checkOutput("enc_multi", 32'(Key_Multi), 32'($countones(prev_press) > 1));
      end else begin
        checkOutput("enc_idle_valid", 32'(Key_Valid), 32'd0);
        checkOutput("enc_idle_multi", 32'(Key_Multi), 32'd0);
        checkOutput("enc_hold_code", 32'(Key_Code), 32'(exp_code));
      end
      if ((Key_Press | Key_Release) != 8'h00)
        checkOutput("press_rel_overlap", 32'(Key_Press & Key_Release), 32'd0);
      for (int k = 0; k < 8; k++) begin
        if (Key_Press[k]) begin
          press_cnt[k]++;
          if (press_cyc[k] < 0) press_cyc[k] = cyc;
        end
        if (Key_Release[k]) begin
          rel_cnt[k]++;
          if (rel_cyc[k] < 0) rel_cyc[k] = cyc;
        end
      end
      if (Key_Press != 8'h00 && first_vec == 8'h00) first_vec = Key_Press;
      prev_press = Key_Press;
    end
  end

  initial begin
    logic [7:0] mask;
    int         g, lat;

    clearCounts();
    #2 RSTn = 1'b0;
    waitCycles(3);
    checkOutput("rst_state", 32'(Key_State), 32'h00);
    checkOutput("rst_press", 32'(Key_Press), 32'h00);
    checkOutput("rst_release", 32'(Key_Release), 32'h00);
    checkOutput("rst_valid", 32'(Key_Valid), 32'd0);
    checkOutput("rst_code", 32'(Key_Code), 32'd0);
    checkOutput("rst_multi", 32'(Key_Multi), 32'd0);
    @(negedge CLK);
    #1 RSTn = 1'b1;
    waitCycles(100);
    for (int k = 0; k < 8; k++) begin
      checkOutput("idle_press_cnt", 32'(press_cnt[k]), 32'd0);
      checkOutput("idle_rel_cnt", 32'(rel_cnt[k]), 32'd0);
    end

    $display("[TB] clean press/release on key 2");
    clearCounts();
    waitCycles(4);
    applyStimulus(8'hFB);
    waitCycles(100);
    checkOutput("k2_press_cnt", 32'(press_cnt[2]), 32'd1);
    lat = press_cyc[2] - t_drive - 1;
    checkOutput("k2_press_latency_in_window", 32'(inWindow(lat)), 32'd1);
    checkOutput("k2_state_pressed", 32'(Key_State), 32'h04);
    checkOutput("k2_code", 32'(Key_Code), 32'd2);
    applyStimulus(8'hFF);
    waitCycles(100);
    checkOutput("k2_rel_cnt", 32'(rel_cnt[2]), 32'd1);
    lat = rel_cyc[2] - t_drive - 1;
    checkOutput("k2_rel_latency_in_window", 32'(inWindow(lat)), 32'd1);
    checkOutput("k2_state_released", 32'(Key_State), 32'h00);
    checkOutput("k2_press_cnt_after", 32'(press_cnt[2]), 32'd1);

    $display("[TB] bounce rejection on key 5");
    clearCounts();
    for (int i = 0; i < 14; i++) begin
      applyStimulus((i % 2 == 0) ? 8'hDF : 8'hFF);
      waitCycles(14);
    end
    applyStimulus(8'hFF);
    waitCycles(100);
    checkOutput("k5_press_cnt", 32'(press_cnt[5]), 32'd0);
    checkOutput("k5_rel_cnt", 32'(rel_cnt[5]), 32'd0);
    checkOutput("k5_state", 32'(Key_State), 32'h00);

    $display("[TB] simultaneous press on keys 6 and 1");
    clearCounts();
    applyStimulus(8'hBD);
    waitCycles(100);
    checkOutput("sim_press_vec", 32'(first_vec), 32'h42);
    checkOutput("sim_press_cnt1", 32'(press_cnt[1]), 32'd1);
    checkOutput("sim_press_cnt6", 32'(press_cnt[6]), 32'd1);
    checkOutput("sim_code", 32'(Key_Code), 32'd1);
    applyStimulus(8'hFF);
    waitCycles(100);
    checkOutput("sim_rel_cnt1", 32'(rel_cnt[1]), 32'd1);
    checkOutput("sim_rel_cnt6", 32'(rel_cnt[6]), 32'd1);

    $display("[TB] reset during debounce on key 0");
    clearCounts();
    applyStimulus(8'hFE);
    waitCycles(20);
    checkOutput("mid_no_press", 32'(press_cnt[0]), 32'd0);
    @(negedge CLK);
    #1 RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checkOutput("mid_rst_state", 32'(Key_State), 32'h00);
    checkOutput("mid_rst_code", 32'(Key_Code), 32'd0);
    clearCounts();
    RSTn    = 1'b1;
    t_drive = cyc;
    waitCycles(60);
    checkOutput("mid_fresh_press_cnt", 32'(press_cnt[0]), 32'd1);
    lat = press_cyc[0] - t_drive - 1;
    checkOutput("mid_fresh_latency_in_window", 32'(inWindow(lat)), 32'd1);
    checkOutput("mid_state", 32'(Key_State), 32'h01);
    applyStimulus(8'hFF);
    waitCycles(60);

    $display("[TB] long hold on key 7");
    clearCounts();
    applyStimulus(8'h7F);
    waitCycles(1000);
    checkOutput("k7_press_cnt", 32'(press_cnt[7]), 32'd1);
    checkOutput("k7_state", 32'(Key_State), 32'h80);
    checkOutput("k7_code", 32'(Key_Code), 32'd7);
    applyStimulus(8'hFF);
    waitCycles(100);
    checkOutput("k7_rel_cnt", 32'(rel_cnt[7]), 32'd1);
    checkOutput("k7_code_held", 32'(Key_Code), 32'd7);

    $display("[TB] randomized multi-key presses");
    for (int r = 0; r < 10; r++) begin
      clearCounts();
      mask = 8'($urandom_range(1, 255));
      waitCycles($urandom_range(0, 9));
      if (mask != 8'hFF) begin
        g = $urandom_range(0, 7);
        while (mask[g]) g = (g + 1) % 8;
        applyStimulus(~(8'h01 << g));
        waitCycles($urandom_range(1, 15));
        applyStimulus(8'hFF);
        waitCycles(5);
      end
      applyStimulus(~mask);
      waitCycles(50);
      checkOutput("rnd_press_vec", 32'(first_vec), 32'(mask));
      checkOutput("rnd_state", 32'(Key_State), 32'(mask));
      checkOutput("rnd_code", 32'(Key_Code), 32'(lowestIdx(mask)));
      lat = press_cyc[lowestIdx(mask)] - t_drive - 1;
      checkOutput("rnd_latency_in_window", 32'(inWindow(lat)), 32'd1);
      for (int k = 0; k < 8; k++)
        checkOutput("rnd_press_cnt", 32'(press_cnt[k]), 32'(mask[k]));
      applyStimulus(8'hFF);
      waitCycles(50);
      checkOutput("rnd_state_rel", 32'(Key_State), 32'h00);
      for (int k = 0; k < 8; k++)
        checkOutput("rnd_rel_cnt", 32'(rel_cnt[k]), 32'(mask[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
